mem_copy_dma: RTL and testbench
===============================

Name: mem_copy_dma

Overview:
Bus initiator that copies a block of 32-bit words from one region of the data RAM to another. It drives the RAM port (MemRd, MemWr, Addr, WrData) and samples RdData, reading one word and then writing it. It sits beside the CPU datapath on the shared data-RAM port. An external arbiter grants it the port with mem_gnt; the block raises mem_req while it wants the port.

Parameters:
RAM_SIZE, 256, RAM depth in 32-bit words; used for range checking
LEN_W, 9, width of the transfer length in words (maximum 2^LEN_W-1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle command strobe; sampled only in IDLE
src_addr  input  32  source byte address; must be word aligned
dst_addr  input  32  destination byte address; must be word aligned
len  input  LEN_W  number of words to copy
mem_req  output  1  port request to the arbiter
mem_gnt  input  1  port grant; may drop in any cycle
MemRd  output  1  RAM read enable
MemWr  output  1  RAM write enable
Addr  output  32  RAM byte address
WrData  output  32  RAM write data
RdData  input  32  RAM read data, combinational from Addr/MemRd
busy  output  1  high while a copy is in progress
done  output  1  one-cycle pulse when a copy completes
err  output  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE; pointers, count and data buffer go to 0.
  - All outputs are 0, including Addr and WrData.
  - Reset mid-copy aborts immediately. MemWr drops combinationally with the state, so no partial write occurs after reset asserts.
  - No done or err pulse is generated for an aborted copy.
- States: IDLE, RD, WR, FIN, ERR.
- IDLE with start=1, command checks:
  - Rejected if src_addr[1:0]!=0, dst_addr[1:0]!=0, src_addr[31:2]+len>RAM_SIZE, or dst_addr[31:2]+len>RAM_SIZE. Sums are computed at 33 bits with no wrap. Next state is ERR.
  - Otherwise, if len==0, next state is FIN and no memory access is made.
  - Otherwise latch src_ptr=src_addr, dst_ptr=dst_addr, remaining=len. Next state is RD.
- start outside IDLE is ignored; commands are not queued.
- mem_req=1 in RD and WR only. MemRd and MemWr are gated combinationally by mem_gnt.
- RD state:
  - Addr=src_ptr; MemRd=mem_gnt.
  - On a clock edge with mem_gnt=1: buf<=RdData, src_ptr+=4, next state WR.
  - With mem_gnt=0: hold state. Addr may still show src_ptr, but MemRd=0.
- WR state:
  - Addr=dst_ptr; WrData=buf; MemWr=mem_gnt.
  - On a clock edge with mem_gnt=1: the RAM writes; dst_ptr+=4; remaining-=1.
  - Next state is FIN if remaining was 1, else RD.
  - With mem_gnt=0: hold; MemWr=0.
- FIN: done=1 for exactly one cycle, then IDLE.
- ERR: err=1 for exactly one cycle, then IDLE.
- busy=1 in RD, WR and FIN; 0 in IDLE and ERR.
- Outside RD/WR, MemRd=MemWr=0 and Addr=0.
- Latency with mem_gnt tied high and len=N>0:
  - start is sampled at edge 0; RD is active in cycle 1.
  - The last write occurs at edge 2N.
  - done is high in cycle 2N+1.
- Overlap: the copy is strictly forward, one word at a time. When dst>src and the regions overlap, source words are overwritten before they are read; this replication is the defined behaviour.
- Pointers are 32-bit and increment by 4. They cannot exceed the RAM range because of the start check.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=0, RD=1, WR=2, FIN=3, ERR=4; 3 bits)
  - WORD_BYTES=4
  - the RAM_SIZE default, shared with the RAM block
- No sub-module: a single module with one state register, two address pointers, a down-counter and a 32-bit data buffer.

Test Plan:
1. Preload RAM[0..3]=0x11,0x22,0x33,0x44; gnt=1; start src=0x0 dst=0x40 len=4 -> RAM[16..19]=0x11..0x44; done pulse in cycle 9; busy high cycles 1-9; exactly 4 MemWr cycles.
2. src=0x2 (misaligned) dst=0x40 len=1 -> err pulse in cycle 1; no MemRd or MemWr ever asserted; then IDLE.
3. src=0x3F8 dst=0x0 len=3 (word 254+3>256) -> err pulse; RAM unchanged. len=0 with valid addresses -> done pulse in cycle 1 with no access.
4. mem_gnt toggles 1,0,0,1,... during a len=2 copy -> MemRd/MemWr never high while gnt=0; data still correct; done delayed by exactly the number of gnt=0 cycles spent in RD/WR.
5. Assert reset in the WR state of word 2 of a len=4 copy -> MemWr=0 immediately; only word 1 is written; outputs all 0; no done; a new start after reset succeeds.
6. Overlap: RAM[0..2]=A,B,C; src=0x0 dst=0x4 len=2 -> RAM[1]=A, RAM[2]=A. A start pulse while busy is ignored, so no second copy occurs.

Source files
------------

// File: rtl/mem_copy_dma_pkg.sv
// rtl/mem_copy_dma_pkg.sv - shared state encoding and sizing constants for the copy engine
package mem_copy_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_FIN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam int WORD_BYTES       = 4;
  localparam int RAM_SIZE_DEFAULT = 256;

endpackage

// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - word-at-a-time RAM-to-RAM block copier on the shared data port
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int RAM_SIZE = RAM_SIZE_DEFAULT,
  parameter int LEN_W    = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic             MemRd,
  output logic             MemWr,
  output logic [31:0]      Addr,
  output logic [31:0]      WrData,
  input  logic [31:0]      RdData,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [32:0] RAM_LIMIT = 33'(RAM_SIZE);

  state_t           state, state_nxt;
  logic [31:0]      src_ptr, dst_ptr, data_buf;
  logic [LEN_W-1:0] remaining;
  logic [32:0]      src_end, dst_end;
  logic             cmd_bad;

  // End-of-region word indices at 33 bits so a huge base cannot wrap past the check.
  assign src_end = {3'b000, src_addr[31:2]} + {{(33-LEN_W){1'b0}}, len};
  assign dst_end = {3'b000, dst_addr[31:2]} + {{(33-LEN_W){1'b0}}, len};
  assign cmd_bad = (|src_addr[1:0]) || (|dst_addr[1:0]) ||
                   (src_end > RAM_LIMIT) || (dst_end > RAM_LIMIT);

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    Addr      = 32'h0;
    WrData    = 32'h0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (cmd_bad)                 state_nxt = S_ERR;
          else if (len == '0)          state_nxt = S_FIN;
          else                         state_nxt = S_RD;
        end
      end
      S_RD: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        Addr    = src_ptr;
        MemRd   = mem_gnt;
        if (mem_gnt) state_nxt = S_WR;
      end
      S_WR: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        Addr    = dst_ptr;
        WrData  = data_buf;
        MemWr   = mem_gnt;
        if (mem_gnt) state_nxt = (remaining == LEN_W'(1)) ? S_FIN : S_RD;
      end
      S_FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        err       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      src_ptr   <= 32'h0;
      dst_ptr   <= 32'h0;
      remaining <= '0;
      data_buf  <= 32'h0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start && !cmd_bad && (len != '0)) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= len;
          end
        end
        S_RD: begin
          if (mem_gnt) begin
            data_buf <= RdData;
            src_ptr  <= src_ptr + 32'(WORD_BYTES);
          end
        end
        S_WR: begin
          if (mem_gnt) begin
            dst_ptr   <= dst_ptr + 32'(WORD_BYTES);
            remaining <= remaining - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb/tb_mem_copy_dma.sv - self-checking bench for mem_copy_dma with a RAM and reference model
module tb_mem_copy_dma;

  localparam int BUDGET = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [8:0]  len;
  logic        mem_req, mem_gnt, MemRd, MemWr;
  logic [31:0] Addr, WrData, RdData;
  logic        busy, done, err;

  logic [31:0] ram     [0:255];
  logic [31:0] ref_ram [0:255];
  logic        pre_we;
  logic [7:0]  pre_a;
  logic [31:0] pre_d;
  bit          gnt_pat [0:BUDGET];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mem_copy_dma #(.RAM_SIZE(256), .LEN_W(9)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .mem_req(mem_req), .mem_gnt(mem_gnt), .MemRd(MemRd), .MemWr(MemWr),
    .Addr(Addr), .WrData(WrData), .RdData(RdData), .busy(busy), .done(done), .err(err)
  );

  assign RdData = MemRd ? ram[Addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (pre_we)     ram[pre_a] <= pre_d;
    else if (MemWr) ram[Addr[9:2]] <= WrData;
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_ram(input string nm);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_ram[i]) bad++;
    chk(nm, bad, 0);
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    pre_we = 1'b1; pre_a = 8'(a); pre_d = d;
    ref_ram[a] = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  function automatic bit model_rejects(input logic [31:0] s, input logic [31:0] d, input int n);
    longint sw = longint'(s) / 4;
    longint dw = longint'(d) / 4;
    return (s % 4 != 0) || (d % 4 != 0) || (sw + n > 256) || (dw + n > 256);
  endfunction

  // Every word needs one granted read cycle and one granted write cycle; done follows the last.
  function automatic int model_cycle(input bit rej, input int n);
    int grants = 0;
    if (rej || n == 0) return 1;
    for (int c = 1; c <= BUDGET; c++) begin
      if (gnt_pat[c]) grants++;
      if (grants == 2 * n) return c + 1;
    end
    return -1;
  endfunction

  task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input int n, input int gm,
                         input bit poke, input bit exp_err, input int exp_cyc_in, input string nm);
    int  rd_n = 0, wr_n = 0, viol = 0, busy_bad = 0, idle_bad = 0;
    int  got_cyc = 0, exp_cyc;
    bit  got_done = 0, got_err = 0;
    bit  rej;
    for (int c = 0; c <= BUDGET; c++) begin
      case (gm)
        0:       gnt_pat[c] = 1'b1;
        1:       gnt_pat[c] = (c % 3 == 1);
        default: gnt_pat[c] = (c % 4 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
    end
    rej     = model_rejects(s, d, n);
    exp_cyc = (exp_cyc_in > 0) ? exp_cyc_in : model_cycle(rej, n);
    if (!rej && n > 0)
      for (int i = 0; i < n; i++) ref_ram[d / 4 + i] = ref_ram[s / 4 + i];

    src_addr = s; dst_addr = d; len = 9'(n); start = 1'b1; mem_gnt = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= BUDGET && got_cyc == 0; c++) begin
      mem_gnt = gnt_pat[c];
      if (poke && c == 2) begin
        start = 1'b1; src_addr = 32'h40; dst_addr = 32'h80; len = 9'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (MemRd) rd_n++;
      if (MemWr) wr_n++;
      if ((MemRd || MemWr) && !mem_gnt) viol++;
      if (busy != !exp_err) busy_bad++;
      if (done || err) begin
        got_cyc = c; got_done = done; got_err = err;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; mem_gnt = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy || done || err || MemRd || MemWr || mem_req) idle_bad++;
    end
    @(posedge clk); #1;

    chk({nm, " pulse_cycle"}, got_cyc, exp_cyc);
    chk({nm, " err"}, got_err, exp_err);
    chk({nm, " done"}, got_done, !exp_err);
    chk({nm, " reads"}, rd_n, exp_err ? 0 : n);
    chk({nm, " writes"}, wr_n, exp_err ? 0 : n);
    chk({nm, " access_without_gnt"}, viol, 0);
    chk({nm, " busy"}, busy_bad, 0);
    chk({nm, " idle_after"}, idle_bad, 0);
    chk_ram({nm, " ram"});
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          n;
    int          gm;
    bit          poke;
    bit          exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vt [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{32'h0,   32'h40,       4,   0, 0, 0, 9};
    vt[1]  = '{32'h2,   32'h40,       1,   0, 0, 1, 1};
    vt[2]  = '{32'h3F8, 32'h0,        3,   0, 0, 1, 1};
    vt[3]  = '{32'h10,  32'h20,       0,   0, 0, 0, 1};
    vt[4]  = '{32'h100, 32'h180,      2,   1, 0, 0, 11};
    vt[5]  = '{32'h0,   32'h4,        2,   0, 1, 0, 5};
    vt[6]  = '{32'h3FC, 32'h0,        1,   0, 0, 0, 3};
    vt[7]  = '{32'h0,   32'h41,       1,   0, 0, 1, 1};
    vt[8]  = '{32'h0,   32'hFFFFFFFC, 1,   0, 0, 1, 1};
    vt[9]  = '{32'h0,   32'h0,        511, 0, 0, 1, 1};
    vt[10] = '{32'h200, 32'h300,      64,  0, 0, 0, 129};

    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    mem_gnt = 1'b0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ctl", {mem_req, MemRd, MemWr, busy, done, err}, 0);
    chk("reset Addr", Addr, 0);
    chk("reset WrData", WrData, 0);
    reset = 1'b0;

    for (int i = 0; i < 256; i++) preload(i, (i < 4) ? 32'((i + 1) * 32'h11) : $urandom);

    for (int i = 0; i < 11; i++)
      run_cmd(vt[i].src, vt[i].dst, vt[i].n, vt[i].gm, vt[i].poke, vt[i].exp_err,
              vt[i].exp_cyc, $sformatf("vec%0d", i));
    chk("copy ram19", ram[19], 32'h44);
    chk("overlap ram1", ram[1], 32'h11);
    chk("overlap ram2", ram[2], 32'h11);

    // Reset while the second word of a four-word copy is in its write cycle.
    src_addr = 32'h0; dst_addr = 32'h200; len = 9'd4; start = 1'b1; mem_gnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("midcopy wr_before_reset", MemWr, 1);
    reset = 1'b1;
    #1;
    chk("midcopy MemWr", MemWr, 0);
    chk("midcopy ctl", {mem_req, MemRd, MemWr, busy, done, err}, 0);
    chk("midcopy Addr", Addr, 0);
    chk("midcopy WrData", WrData, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ref_ram[128] = ref_ram[0];
    begin
      int pulses = 0;
      repeat (6) begin
        @(negedge clk);
        if (done || err || busy) pulses++;
      end
      chk("midcopy no_done", pulses, 0);
    end
    @(posedge clk); #1;
    chk_ram("midcopy ram");
    run_cmd(32'h40, 32'h300, 3, 0, 0, 0, 7, "after_reset");

    for (int k = 0; k < 25; k++) begin
      logic [31:0] s, d;
      int          n;
      s = 32'($urandom_range(0, 255)) * 4;
      d = 32'($urandom_range(0, 255)) * 4;
      if ($urandom_range(0, 7) == 0) s = s | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) d = d | 32'($urandom_range(1, 3));
      n = $urandom_range(0, 12);
      run_cmd(s, d, n, 2, 1'($urandom_range(0, 1)), model_rejects(s, d, n), 0,
              $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
